coeff_packer: RTL and testbench
===============================

Name: coeff_packer

Overview:
Downstream stage of the 16-entry coefficient FIFO. Pops 13-bit coefficients with a ready/valid handshake and packs them LSB-first into a dense 32-bit word stream for the output bus.
Frames are N_COEFFS coefficients long. The last word of each frame is zero-padded and flagged with out_last. After that word the block restarts on a fresh, bit-0-aligned frame.

Parameters:
COEFF_W, 13, coefficient width in bits (q = 8192)
WORD_W, 32, output word width in bits
N_COEFFS, 701, coefficients per frame. Default gives 9113 bits = 285 words; the last word carries 25 valid bits.

Ports:
clk  input  1  clock; all logic on the rising edge
resetn  input  1  synchronous reset, active-high (asserted = 1) despite the name
in_coeff  input  COEFF_W  coefficient from the FIFO out port
in_valid  input  1  coefficient available (FIFO out_valid)
in_ready  output  1  pop strobe to the FIFO (drives FIFO out_ready)
out_data  output  WORD_W  packed word
out_valid  output  1  out_data valid
out_ready  input  1  downstream accepts the word
out_last  output  1  current word is the final word of the frame

Behaviour:
- Stream mapping: coefficient i occupies frame bits [13i+12:13i]. Word k is frame bits [32k+31:32k]. Bits past 13*N_COEFFS in the final word are 0.
- State:
  - acc: 44-bit shift accumulator (WORD_W+COEFF_W-1).
  - fill: 6-bit count of valid acc bits.
  - cnt: coefficient counter, 0..N_COEFFS-1.
  - FSM: PACK, FLUSH.
- Reset (resetn=1 at a clock edge): acc=0, fill=0, cnt=0, state=PACK.
  - Outputs during/after reset: out_valid=0, out_last=0, out_data=0, in_ready=1 (combinational from PACK).
  - Reset mid-frame discards partial data. No word is emitted for the aborted frame.
- out_data = acc[31:0], combinational.
- out_valid:
  - PACK: out_valid = (fill >= 32).
  - FLUSH: out_valid = (fill > 0).
- out_last = FLUSH && fill <= 32 && fill > 0.
- in_ready = PACK && (fill < 32 || out_ready).
  - This is a combinational path from out_ready to in_ready. It is intentional: it gives full throughput.
- Output handshake (out_valid && out_ready): acc shifts right by 32 with zero fill. fill becomes max(fill-32, 0).
- Input handshake (in_valid && in_ready): in_coeff is ORed into acc at bit position fill, after any same-cycle output shift. fill increases by 13.
  - Max fill is 44, so acc never overflows.
- Simultaneous pop and push in one cycle is legal and required. The output shift applies before the insert.
- cnt increments on every input handshake. When the accepted coefficient is number N_COEFFS-1: cnt returns to 0 and state goes to FLUSH.
- FLUSH:
  - in_ready = 0.
  - Words drain until the out_last word handshakes.
  - At that handshake: state goes to PACK and fill = 0.
  - When the exact frame size is a multiple of 32 (e.g. N_COEFFS=32), the word with fill==32 is the last word.
- out_valid, once asserted, holds with stable out_data until out_ready. Words are never dropped or reordered.
- in_valid low stalls packing with no bubbles inserted into the output.
- Throughput: one coefficient per cycle sustained while out_ready=1. Words come out as bits accumulate.
- Latency: a word is valid the cycle after the input handshake that makes fill >= 32.

Test Plan:
1. Single word, N_COEFFS=701: coefficients 0x1FFF, 0x0001, 0x0ABC, out_ready=1 -> first word 0xF0003FFF with out_last=0. Bits 6:0 of the next word = 0x2A.
2. Short frame, N_COEFFS=5: five coefficients of 0x1FFF -> exactly 3 words: 0xFFFFFFFF, 0xFFFFFFFF, 0x00000001. out_last is set only on the third.
3. Default N=701, all coefficients 0x1FFF, continuous valid/ready -> 285 words. Words 0-283 = 0xFFFFFFFF; word 284 = 0x01FFFFFF with out_last=1. 701 input handshakes total.
4. Backpressure: out_ready held 0 for 20 cycles mid-frame -> in_ready falls once fill >= 32. out_data stays stable. After release, the stream matches a reference packing of random coefficients bit-exactly.
5. Back-to-back frames, N_COEFFS=5, random coefficients -> the second frame's first word starts at bit 0, and each frame has exactly one out_last.
6. resetn=1 pulsed during the word-2 stall -> next cycle out_valid=0, in_ready=1. The next frame packs from bit 0 with no residue.

Source files
------------

// File: rtl/coeff_packer.sv
// coeff_packer: pops COEFF_W-bit coefficients from the coefficient FIFO and
// packs them LSB-first into a dense WORD_W-bit word stream. Each frame holds
// N_COEFFS coefficients. The final word of a frame is zero-padded and flagged
// with out_last, and the next frame starts again at bit 0.
//
// Ports:
//   clk        rising-edge clock
//   resetn     synchronous reset, active-high (asserted = 1) despite the name
//   in_coeff   coefficient from the FIFO
//   in_valid   coefficient available
//   in_ready   pop strobe to the FIFO (combinational, depends on out_ready)
//   out_data   packed word (low WORD_W bits of the accumulator)
//   out_valid  out_data valid
//   out_ready  downstream accepts the word
//   out_last   current word is the final word of the frame
module coeff_packer #(
  parameter int COEFF_W  = 13,
  parameter int WORD_W   = 32,
  parameter int N_COEFFS = 701
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic [COEFF_W-1:0] in_coeff,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [WORD_W-1:0]  out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_last
);

  localparam int ACC_W  = WORD_W + COEFF_W - 1;
  localparam int FILL_W = $clog2(ACC_W + 1);
  localparam int CNT_W  = (N_COEFFS > 1) ? $clog2(N_COEFFS) : 1;

  localparam logic [FILL_W-1:0] WORD_FILL  = FILL_W'(WORD_W);
  localparam logic [FILL_W-1:0] COEFF_FILL = FILL_W'(COEFF_W);
  localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(N_COEFFS - 1);

  typedef enum logic {
    PACK,
    FLUSH
  } state_t;

  state_t              state, state_next;
  logic [ACC_W-1:0]    acc, acc_next;
  logic [FILL_W-1:0]   fill, fill_next;
  logic [CNT_W-1:0]    cnt, cnt_next;
  logic                pop, push;

  always_ff @(posedge clk) begin
    if (resetn) begin
      state <= PACK;
      acc   <= '0;
      fill  <= '0;
      cnt   <= '0;
    end else begin
      state <= state_next;
      acc   <= acc_next;
      fill  <= fill_next;
      cnt   <= cnt_next;
    end
  end

  assign out_data = acc[WORD_W-1:0];

  always_comb begin
    state_next = state;
    acc_next   = acc;
    fill_next  = fill;
    cnt_next   = cnt;
    out_valid  = 1'b0;
    out_last   = 1'b0;
    in_ready   = 1'b0;

    case (state)
      PACK: begin
        out_valid = (fill >= WORD_FILL);
        // A full word that leaves this cycle frees room for the next
        // coefficient, so out_ready feeds straight into in_ready.
        in_ready  = (fill < WORD_FILL) || out_ready;
      end
      FLUSH: begin
        out_valid = (fill != '0);
        out_last  = (fill != '0) && (fill <= WORD_FILL);
      end
      default: begin
        state_next = PACK;
      end
    endcase

    pop  = out_valid && out_ready;
    push = in_valid && in_ready;

    // Output shift is applied first so a same-cycle insert lands at the
    // post-shift fill position.
    if (pop) begin
      acc_next  = acc >> WORD_W;
      fill_next = (fill > WORD_FILL) ? (fill - WORD_FILL) : '0;
    end

    if (push) begin
      acc_next  = acc_next | (ACC_W'(in_coeff) << fill_next);
      fill_next = fill_next + COEFF_FILL;
      if (cnt == CNT_LAST) begin
        cnt_next   = '0;
        state_next = FLUSH;
      end else begin
        cnt_next = cnt + 1'b1;
      end
    end

    if (pop && out_last) begin
      state_next = PACK;
      fill_next  = '0;
      acc_next   = '0;
    end
  end

endmodule

// File: tb/tb_coeff_packer.sv
// Bench for coeff_packer: one instance with the default frame length (701)
// and one with a 5-coefficient frame. Expected words come from a bit-vector
// reference packing of the coefficients the bench drives.
module tb_coeff_packer;

  logic        clk = 1'b0;
  logic        resetn;
  logic [12:0] in_coeff  [2];
  logic        in_valid  [2];
  logic        in_ready  [2];
  logic [31:0] out_data  [2];
  logic        out_valid [2];
  logic        out_ready [2];
  logic        out_last  [2];

  always #5 clk = ~clk;

  coeff_packer #(.COEFF_W(13), .WORD_W(32), .N_COEFFS(701)) u_dut_long (
    .clk      (clk),
    .resetn   (resetn),
    .in_coeff (in_coeff[0]),
    .in_valid (in_valid[0]),
    .in_ready (in_ready[0]),
    .out_data (out_data[0]),
    .out_valid(out_valid[0]),
    .out_ready(out_ready[0]),
    .out_last (out_last[0])
  );

  coeff_packer #(.COEFF_W(13), .WORD_W(32), .N_COEFFS(5)) u_dut_short (
    .clk      (clk),
    .resetn   (resetn),
    .in_coeff (in_coeff[1]),
    .in_valid (in_valid[1]),
    .in_ready (in_ready[1]),
    .out_data (out_data[1]),
    .out_valid(out_valid[1]),
    .out_ready(out_ready[1]),
    .out_last (out_last[1])
  );

  // Word/handshake capture, sampled on the falling edge.
  logic [31:0] wq0[$], wq1[$];
  logic        lq0[$], lq1[$];
  int          hs0 = 0;

  always @(negedge clk) begin
    if (out_valid[0] && out_ready[0]) begin
      wq0.push_back(out_data[0]);
      lq0.push_back(out_last[0]);
    end
    if (out_valid[1] && out_ready[1]) begin
      wq1.push_back(out_data[1]);
      lq1.push_back(out_last[1]);
    end
    if (in_valid[0] && in_ready[0]) hs0++;
  end

  int          errors = 0;
  int          checks = 0;
  logic [12:0] stim[$];
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic push(input int idx, input logic [12:0] c);
    int n = 0;
    in_coeff[idx] = c;
    in_valid[idx] = 1'b1;
    @(negedge clk);
    while (!in_ready[idx] && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready[idx]) check("push_ready_timeout", 32'(in_ready[idx]), 32'd1);
    @(posedge clk);
    #1;
    in_valid[idx] = 1'b0;
  endtask

  task automatic wait_words(input int idx, input int target);
    int t = 0;
    while (((idx == 0) ? wq0.size() : wq1.size()) < target && t < 3000) begin
      @(negedge clk);
      t++;
    end
    repeat (5) @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic ref_pack(input int first, input int n);
    logic [9151:0] bits;
    logic [12:0]   c;
    int            nw;
    bits = '0;
    for (int i = 0; i < n; i++) begin
      c = stim[first + i];
      for (int b = 0; b < 13; b++) bits[13 * i + b] = c[b];
    end
    nw = (13 * n + 31) / 32;
    for (int k = 0; k < nw; k++) exp_q.push_back(bits[32 * k +: 32]);
  endtask

  task automatic pulse_reset();
    resetn = 1'b1;
    @(posedge clk);
    #1;
    resetn = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, hbase, bad, lasts, t, unstable;
    logic [31:0] held;

    resetn = 1'b1;
    for (int i = 0; i < 2; i++) begin
      in_valid[i]  = 1'b0;
      in_coeff[i]  = '0;
      out_ready[i] = 1'b1;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      check("rst_out_valid", 32'(out_valid[i]), 32'd0);
      check("rst_out_last", 32'(out_last[i]), 32'd0);
      check("rst_out_data", out_data[i], 32'd0);
      check("rst_in_ready", 32'(in_ready[i]), 32'd1);
    end
    resetn = 1'b0;

    // 1: first word of a long frame, and the carry-over bits.
    base = wq0.size();
    push(0, 13'h1FFF);
    push(0, 13'h0001);
    push(0, 13'h0ABC);
    @(negedge clk);
    check("t1_latency_valid", 32'(out_valid[0]), 32'd1);
    check("t1_data", out_data[0], 32'hF0003FFF);
    check("t1_last", 32'(out_last[0]), 32'd0);
    @(posedge clk);
    #1;
    check("t1_word_captured", wq0[base], 32'hF0003FFF);
    check("t1_next_bits", {25'd0, out_data[0][6:0]}, 32'h2A);
    check("t1_after_pop_valid", 32'(out_valid[0]), 32'd0);
    pulse_reset();

    // 2: short frame of all-ones.
    base = wq1.size();
    repeat (5) push(1, 13'h1FFF);
    wait_words(1, base + 3);
    check("t2_word_count", wq1.size() - base, 32'd3);
    check("t2_w0", wq1[base], 32'hFFFFFFFF);
    check("t2_w1", wq1[base + 1], 32'hFFFFFFFF);
    check("t2_w2", wq1[base + 2], 32'h00000001);
    check("t2_l0", 32'(lq1[base]), 32'd0);
    check("t2_l1", 32'(lq1[base + 1]), 32'd0);
    check("t2_l2", 32'(lq1[base + 2]), 32'd1);

    // 3: full default frame, continuous flow.
    base  = wq0.size();
    hbase = hs0;
    repeat (701) push(0, 13'h1FFF);
    wait_words(0, base + 285);
    check("t3_word_count", wq0.size() - base, 32'd285);
    bad = 0;
    lasts = 0;
    for (int k = 0; k < 285 && base + k < wq0.size(); k++) begin
      if (k < 284 && wq0[base + k] !== 32'hFFFFFFFF) bad++;
      if (lq0[base + k]) lasts++;
    end
    check("t3_full_words", bad, 32'd0);
    check("t3_last_word", wq0[base + 284], 32'h01FFFFFF);
    check("t3_last_flag", 32'(lq0[base + 284]), 32'd1);
    check("t3_last_count", lasts, 32'd1);
    check("t3_handshakes", hs0 - hbase, 32'd701);
    check("t3_ready_after", 32'(in_ready[0]), 32'd1);

    // 4: backpressure mid-frame with random coefficients.
    stim.delete();
    exp_q.delete();
    for (int i = 0; i < 701; i++) stim.push_back(13'($urandom_range(0, 8191)));
    ref_pack(0, 701);
    base = wq0.size();
    fork
      begin
        for (int i = 0; i < 701; i++) push(0, stim[i]);
      end
      begin
        t = 0;
        while (wq0.size() < base + 3 && t < 2000) begin
          @(negedge clk);
          t++;
        end
        @(posedge clk);
        #1;
        out_ready[0] = 1'b0;
        t = 0;
        @(negedge clk);
        while (!out_valid[0] && t < 100) begin
          @(negedge clk);
          t++;
        end
        held = out_data[0];
        unstable = 0;
        repeat (20) begin
          @(negedge clk);
          if (out_data[0] !== held || !out_valid[0] || in_ready[0]) unstable++;
        end
        check("t4_stall_stable", unstable, 32'd0);
        check("t4_in_ready_low", 32'(in_ready[0]), 32'd0);
        @(posedge clk);
        #1;
        out_ready[0] = 1'b1;
      end
    join
    wait_words(0, base + 285);
    check("t4_word_count", wq0.size() - base, 32'd285);
    bad = 0;
    for (int k = 0; k < 285; k++) begin
      if (base + k >= wq0.size() || wq0[base + k] !== exp_q[k]) bad++;
    end
    check("t4_stream_mismatches", bad, 32'd0);
    check("t4_word0", wq0[base], exp_q[0]);
    check("t4_last_flag", 32'(lq0[base + 284]), 32'd1);

    // 5: back-to-back short frames.
    stim.delete();
    exp_q.delete();
    for (int i = 0; i < 10; i++) stim.push_back(13'($urandom_range(0, 8191)));
    ref_pack(0, 5);
    ref_pack(5, 5);
    base = wq1.size();
    for (int i = 0; i < 10; i++) push(1, stim[i]);
    wait_words(1, base + 6);
    check("t5_word_count", wq1.size() - base, 32'd6);
    bad = 0;
    lasts = 0;
    for (int k = 0; k < 6 && base + k < wq1.size(); k++) begin
      if (wq1[base + k] !== exp_q[k]) bad++;
      if (lq1[base + k]) lasts++;
    end
    check("t5_stream_mismatches", bad, 32'd0);
    check("t5_frame2_word0", wq1[base + 3], exp_q[3]);
    check("t5_last_count", lasts, 32'd2);
    check("t5_last_f1", 32'(lq1[base + 2]), 32'd1);
    check("t5_last_f2", 32'(lq1[base + 5]), 32'd1);

    // 6: reset while the frame's second word is stalled.
    base = wq1.size();
    out_ready[1] = 1'b1;
    for (int i = 0; i < 4; i++) push(1, 13'($urandom_range(0, 8191)));
    out_ready[1] = 1'b0;
    push(1, 13'($urandom_range(0, 8191)));
    repeat (3) @(posedge clk);
    #1;
    check("t6_stalled_valid", 32'(out_valid[1]), 32'd1);
    pulse_reset();
    check("t6_rst_out_valid", 32'(out_valid[1]), 32'd0);
    check("t6_rst_in_ready", 32'(in_ready[1]), 32'd1);
    check("t6_rst_out_data", out_data[1], 32'd0);
    check("t6_rst_out_last", 32'(out_last[1]), 32'd0);
    out_ready[1] = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("t6_aborted_words", wq1.size() - base, 32'd1);
    stim.delete();
    exp_q.delete();
    for (int i = 0; i < 5; i++) stim.push_back(13'($urandom_range(0, 8191)));
    ref_pack(0, 5);
    base = wq1.size();
    for (int i = 0; i < 5; i++) push(1, stim[i]);
    wait_words(1, base + 3);
    check("t6_word_count", wq1.size() - base, 32'd3);
    bad = 0;
    for (int k = 0; k < 3; k++) begin
      if (base + k >= wq1.size() || wq1[base + k] !== exp_q[k]) bad++;
    end
    check("t6_stream_mismatches", bad, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
